// File: rtl/peripheral_axi4_mpram_pkg.sv
// Shared types and constants for the MPRAM-to-AXI4 initiator: FSM states,
// AXI burst/response encodings and the AXI size helper.
package peripheral_axi4_mpram_pkg;

`ifdef PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;
`endif

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic [2:0] axi_size(input int data_width);
    case (data_width)
      8:       axi_size = 3'd0;
      16:      axi_size = 3'd1;
      32:      axi_size = 3'd2;
      64:      axi_size = 3'd3;
      default: axi_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/peripheral_axi4_mpram_watchdog.sv
// Response watchdog: counts cycles while enabled, returns to zero on clear,
// and flags expiry once TIMEOUT_CYCLES-1 is reached.
module peripheral_axi4_mpram_watchdog
  import peripheral_axi4_mpram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  // cycle counter, saturates at the expiry value
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (clear) begin
      count <= {CW{1'b0}};
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/peripheral_axi4_mpram_master.sv
// Single-outstanding AXI4 initiator turning MPRAM req/we/addr/be/data requests
// into single-beat AXI4 transactions. Optional watchdog: PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN.
module peripheral_axi4_mpram_master
  import peripheral_axi4_mpram_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = 4,
  parameter int AXI_USER_WIDTH = 10,
  parameter int MASTER_ID      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [7:0]                  axi_aw_len,
  output logic [2:0]                  axi_aw_size,
  output logic [1:0]                  axi_aw_burst,
  output logic                        axi_aw_lock,
  output logic [3:0]                  axi_aw_cache,
  output logic [2:0]                  axi_aw_prot,
  output logic [3:0]                  axi_aw_qos,
  output logic [3:0]                  axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0]   axi_w_strb,
  output logic                        axi_w_last,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic [1:0]                  axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   axi_b_user,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  output logic [7:0]                  axi_ar_len,
  output logic [2:0]                  axi_ar_size,
  output logic [1:0]                  axi_ar_burst,
  output logic                        axi_ar_lock,
  output logic [3:0]                  axi_ar_cache,
  output logic [2:0]                  axi_ar_prot,
  output logic [3:0]                  axi_ar_qos,
  output logic [3:0]                  axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   axi_r_user,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready
);

  localparam logic [2:0] SIZE = axi_size(AXI_DATA_WIDTH);
  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(MASTER_ID);

  state_e                      state, state_next;
  logic [AXI_ADDR_WIDTH-1:0]   cap_addr;
  logic [AXI_DATA_WIDTH-1:0]   cap_data;
  logic [AXI_STRB_WIDTH-1:0]   cap_be;
  logic                        cap_we;
  logic                        aw_done, w_done;
  logic                        aw_done_next, w_done_next;
  logic                        rvalid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic                        err;
  logic                        in_wr, in_rd, in_resp;
  logic                        accept, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                        timeout_hit;
  logic                        unused_inputs;

  assign in_wr   = (state == ST_WR_REQ);
  assign in_rd   = (state == ST_RD_REQ);
  assign in_resp = (state == ST_WR_RESP) || (state == ST_RD_RESP);
  assign accept  = (state == ST_IDLE) && req_i;

  assign aw_hs = axi_aw_valid && axi_aw_ready;
  assign w_hs  = axi_w_valid && axi_w_ready;
  assign ar_hs = axi_ar_valid && axi_ar_ready;
  assign b_hs  = axi_b_valid && axi_b_ready;
  assign r_hs  = axi_r_valid && axi_r_ready;

  assign aw_done_next = aw_done || aw_hs;
  assign w_done_next  = w_done || w_hs;

`ifdef PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN
  logic wd_expired;

  peripheral_axi4_mpram_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (!in_resp),
    .enable (in_resp),
    .expired(wd_expired)
  );

  // a handshake in the expiry cycle wins over the timeout
  assign timeout_hit = wd_expired && !b_hs && !r_hs;
  assign axi_b_ready = (state == ST_WR_RESP) || ((state == ST_DRAIN) && cap_we);
  assign axi_r_ready = (state == ST_RD_RESP) || ((state == ST_DRAIN) && !cap_we);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign axi_b_ready = (state == ST_WR_RESP);
  assign axi_r_ready = (state == ST_RD_RESP);
`endif

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_i) begin
          state_next = we_i ? ST_WR_REQ : ST_RD_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (aw_done_next && w_done_next) begin
          state_next = ST_WR_RESP;
        end else begin
          state_next = ST_WR_REQ;
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          state_next = ST_IDLE;
`ifdef PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = ST_DRAIN;
`endif
        end else begin
          state_next = ST_WR_RESP;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs) begin
          state_next = ST_RD_RESP;
        end else begin
          state_next = ST_RD_REQ;
        end
      end
      ST_RD_RESP: begin
        if (r_hs) begin
          state_next = ST_IDLE;
`ifdef PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = ST_DRAIN;
`endif
        end else begin
          state_next = ST_RD_RESP;
        end
      end
`ifdef PERIPHERAL_AXI4_MPRAM_MASTER_TIMEOUT_EN
      ST_DRAIN: begin
        if (b_hs || r_hs) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // request capture and per-channel write handshake flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_addr <= {AXI_ADDR_WIDTH{1'b0}};
      cap_data <= {AXI_DATA_WIDTH{1'b0}};
      cap_be   <= {AXI_STRB_WIDTH{1'b0}};
      cap_we   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (accept) begin
      cap_addr <= addr_i;
      cap_data <= data_i;
      cap_be   <= be_i;
      cap_we   <= we_i;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (in_wr) begin
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
    end else begin
      aw_done  <= aw_done;
      w_done   <= w_done;
    end
  end

  // registered response strobe; rdata/err hold between strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid <= 1'b0;
      rdata  <= {AXI_DATA_WIDTH{1'b0}};
      err    <= 1'b0;
    end else if ((state == ST_WR_RESP) && b_hs) begin
      rvalid <= 1'b1;
      rdata  <= {AXI_DATA_WIDTH{1'b0}};
      err    <= axi_b_resp[1];
    end else if ((state == ST_RD_RESP) && r_hs) begin
      rvalid <= 1'b1;
      rdata  <= axi_r_data;
      err    <= axi_r_resp[1];
    end else if (timeout_hit) begin
      rvalid <= 1'b1;
      rdata  <= {AXI_DATA_WIDTH{1'b0}};
      err    <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

  assign gnt_o    = (state == ST_IDLE);
  assign rvalid_o = rvalid;
  assign rdata_o  = rdata;
  assign err_o    = err;

  // fixed fields read as zero outside their request phase
  assign axi_aw_id     = in_wr ? ID : {AXI_ID_WIDTH{1'b0}};
  assign axi_aw_addr   = cap_addr;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = in_wr ? SIZE : 3'd0;
  assign axi_aw_burst  = in_wr ? AXI_BURST_INCR : 2'b00;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'd0;
  assign axi_aw_prot   = 3'd0;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi_aw_valid  = in_wr && !aw_done;

  assign axi_w_data    = cap_data;
  assign axi_w_strb    = cap_be;
  assign axi_w_last    = in_wr;
  assign axi_w_user    = {AXI_USER_WIDTH{1'b0}};
  assign axi_w_valid   = in_wr && !w_done;

  assign axi_ar_id     = in_rd ? ID : {AXI_ID_WIDTH{1'b0}};
  assign axi_ar_addr   = cap_addr;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = in_rd ? SIZE : 3'd0;
  assign axi_ar_burst  = in_rd ? AXI_BURST_INCR : 2'b00;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'd0;
  assign axi_ar_prot   = 3'd0;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi_ar_valid  = in_rd;

  assign unused_inputs = ^{axi_b_id, axi_b_resp[0], axi_b_user, axi_r_id,
                           axi_r_resp[0], axi_r_last, axi_r_user};

endmodule
